// File: rtl/hybrid_compressor_multiplier_4x4_pkg.sv
// rtl/hybrid_compressor_multiplier_4x4_pkg.sv - widths and bit-level adder helpers for the 4x4 multiplier
package hybrid_compressor_multiplier_4x4_pkg;

  localparam int MUL_IN_W  = 4;
  localparam int MUL_OUT_W = 8;

  typedef struct packed {
    logic carry;
    logic sum;
  } add_bits_t;

  function automatic add_bits_t half_add(input logic x, input logic y);
    add_bits_t r;
    r.sum   = x ^ y;
    r.carry = x & y;
    return r;
  endfunction

  function automatic add_bits_t full_add(input logic x, input logic y, input logic z);
    add_bits_t r;
    r.sum   = x ^ y ^ z;
    r.carry = (x & y) | (z & (x ^ y));
    return r;
  endfunction

endpackage

// File: rtl/compressor_4to2.sv
// rtl/compressor_4to2.sv - exact 4:2 compressor, x1+x2+x3+x4+cin = sum + 2*(carry+cout)
module compressor_4to2 (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic cin,
  output logic sum,
  output logic carry,
  output logic cout
);

  logic x12;
  logic x1234;

  // cout depends only on x1..x3, so it never ripples through cin
  always_comb begin
    x12   = x1 ^ x2;
    x1234 = x12 ^ x3 ^ x4;
    sum   = x1234 ^ cin;
    cout  = x12 ? x3 : x1;
    carry = x1234 ? cin : x4;
  end

endmodule

// File: rtl/hybrid_compressor_multiplier_4x4.sv
// rtl/hybrid_compressor_multiplier_4x4.sv - unsigned 4x4 multiplier, HA/FA/4:2 reduction tree, registered product
module hybrid_compressor_multiplier_4x4
  import hybrid_compressor_multiplier_4x4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MUL_IN_W-1:0]  a,
  input  logic [MUL_IN_W-1:0]  b,
  output logic [MUL_OUT_W-1:0] f
);

  logic [MUL_IN_W-1:0][MUL_IN_W-1:0] pp;

  add_bits_t col1_ha;
  add_bits_t col2_fa;
  add_bits_t col2_ha;
  add_bits_t col3_fa;
  add_bits_t col5_fa;

  logic col3_sum, col3_carry, col3_cout;
  logic col4_sum, col4_carry, col4_cout;

  logic [MUL_OUT_W-1:0] row_a;
  logic [MUL_OUT_W-1:0] row_b;

  logic [MUL_OUT_W-1:0] f_d;
  logic [MUL_OUT_W-1:0] f_q;

  // pp[i][j] has weight 2^(i+j)
  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_IN_W; i++) begin
      for (int j = 0; j < MUL_IN_W; j++) begin
        pp[i][j] = a[j] & b[i];
      end
    end
  end

  compressor_4to2 u_col3 (
    .x1    (pp[0][3]),
    .x2    (pp[1][2]),
    .x3    (pp[2][1]),
    .x4    (pp[3][0]),
    .cin   (1'b0),
    .sum   (col3_sum),
    .carry (col3_carry),
    .cout  (col3_cout)
  );

  compressor_4to2 u_col4 (
    .x1    (pp[1][3]),
    .x2    (pp[2][2]),
    .x3    (pp[3][1]),
    .x4    (col3_carry),
    .cin   (col3_cout),
    .sum   (col4_sum),
    .carry (col4_carry),
    .cout  (col4_cout)
  );

  // Columns 0..3 collapse to one bit each; columns 4..6 leave two rows for the ripple adder
  always_comb begin
    col1_ha = half_add(pp[0][1], pp[1][0]);
    col2_fa = full_add(pp[0][2], pp[1][1], pp[2][0]);
    col2_ha = half_add(col2_fa.sum, col1_ha.carry);
    col3_fa = full_add(col3_sum, col2_fa.carry, col2_ha.carry);
    col5_fa = full_add(pp[2][3], pp[3][2], col4_carry);

    row_a = {1'b0, pp[3][3], col5_fa.sum, col4_sum,
             col3_fa.sum, col2_ha.sum, col1_ha.sum, pp[0][0]};
    row_b = {1'b0, col5_fa.carry, col4_cout, col3_fa.carry, 4'b0000};
  end

  // Carry out of bit 7 is always zero since 15*15 fits in 8 bits
  always_comb begin
    add_bits_t rca_bit;
    logic      rca_c;
    f_d     = '0;
    rca_c   = 1'b0;
    rca_bit = '0;
    for (int k = 0; k < MUL_OUT_W; k++) begin
      rca_bit = full_add(row_a[k], row_b[k], rca_c);
      f_d[k]  = rca_bit.sum;
      rca_c   = rca_bit.carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= '0;
    end else begin
      f_q <= f_d;
    end
  end

  assign f = f_q;

endmodule

// File: tb/tb_hybrid_compressor_multiplier_4x4.sv
// tb/tb_hybrid_compressor_multiplier_4x4.sv - scoreboard bench for the 4x4 hybrid compressor multiplier
module tb_hybrid_compressor_multiplier_4x4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] f;

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [7:0] last_v;
  int         tests_run;
  int         tests_failed;

  hybrid_compressor_multiplier_4x4 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .f   (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] prod(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] xe;
    logic [7:0] ye;
    xe = {4'b0000, x};
    ye = {4'b0000, y};
    return xe * ye;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    a   = 4'hF;
    b   = 4'hF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      exp_q.push_back(8'h00);
      @(posedge clk);
      #1;
      tests_run++;
      exp_v = exp_q.pop_front();
      if (f !== exp_v) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: f=%h required %h", c, f, exp_v);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(prod(a, b));
    @(posedge clk);
    #1;
    tests_run++;
    exp_v = exp_q.pop_front();
    if (f !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_release: f=%0d required %0d", f, exp_v);
    end
  endtask

  task automatic test_directed();
    logic [3:0] va[5];
    logic [3:0] vb[5];
    logic [7:0] ve[5];
    va = '{4'd0, 4'd8, 4'd4,  4'd12, 4'd15};
    vb = '{4'd0, 4'd2, 4'd10, 4'd6,  4'd15};
    ve = '{8'd0, 8'd16, 8'd40, 8'd72, 8'd225};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = va[k];
      b = vb[k];
      exp_q.push_back(ve[k]);
      @(posedge clk);
      #1;
      tests_run++;
      exp_v = exp_q.pop_front();
      if (f !== exp_v) begin
        tests_failed++;
        $display("FAIL directed %0dx%0d: f=%0d required %0d", va[k], vb[k], f, exp_v);
      end
    end
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        a = i[3:0];
        b = j[3:0];
        exp_q.push_back(prod(a, b));
        @(posedge clk);
        #1;
        tests_run++;
        exp_v = exp_q.pop_front();
        if (f !== exp_v) begin
          tests_failed++;
          $display("FAIL exhaustive %0dx%0d: f=%0d required %0d", i, j, f, exp_v);
        end
      end
    end
  endtask

  task automatic test_compressor_stress();
    logic [3:0] va[2];
    logic [3:0] vb[2];
    logic [7:0] ve[2];
    va = '{4'hF, 4'hE};
    vb = '{4'hF, 4'h7};
    ve = '{8'd225, 8'd98};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a = va[k];
      b = vb[k];
      exp_q.push_back(ve[k]);
      @(posedge clk);
      #1;
      tests_run++;
      exp_v = exp_q.pop_front();
      if (f !== exp_v) begin
        tests_failed++;
        $display("FAIL col3_stress %0dx%0d: f=%0d required %0d", va[k], vb[k], f, exp_v);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic       r_seq[5];
    logic [7:0] e_seq[5];
    r_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    e_seq = '{8'd81, 8'd81, 8'd0, 8'd81, 8'd81};
    a = 4'd9;
    b = 4'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst = r_seq[k];
      exp_q.push_back(e_seq[k]);
      @(posedge clk);
      #1;
      tests_run++;
      exp_v = exp_q.pop_front();
      if (f !== exp_v) begin
        tests_failed++;
        $display("FAIL midstream_reset step %0d: f=%0d required %0d", k, f, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    a = 4'd3;
    b = 4'd5;
    exp_q.push_back(prod(a, b));
    @(posedge clk);
    #1;
    tests_run++;
    exp_v  = exp_q.pop_front();
    last_v = exp_v;
    if (f !== exp_v) begin
      tests_failed++;
      $display("FAIL hold_capture: f=%0d required %0d", f, exp_v);
    end
    #1;
    a = 4'd7;
    b = 4'd7;
    #1;
    tests_run++;
    if (f !== last_v) begin
      tests_failed++;
      $display("FAIL hold_between_edges a: f=%0d required %0d", f, last_v);
    end
    #4;
    a = 4'd2;
    b = 4'd6;
    exp_q.push_back(prod(a, b));
    #1;
    tests_run++;
    if (f !== last_v) begin
      tests_failed++;
      $display("FAIL hold_between_edges b: f=%0d required %0d", f, last_v);
    end
    @(posedge clk);
    #1;
    tests_run++;
    exp_v = exp_q.pop_front();
    if (f !== exp_v) begin
      tests_failed++;
      $display("FAIL hold_next_edge: f=%0d required %0d", f, exp_v);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    a   = 4'hF;
    b   = 4'hF;
    test_reset();
    test_directed();
    test_exhaustive();
    test_compressor_stress();
    test_midstream_reset();
    test_hold();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
